// File: rtl/qed_pkg.sv
// Shared definitions for the QED duplicate-issue path: RV32I opcodes, the
// canonical NOP, controller states and the register-field remap helper.
package qed_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] QED_NOP = 32'h0000_0013;

  localparam int REG_DUP_BIT = 4;

  typedef enum logic [1:0] {
    QED_IDLE,
    QED_ORIG,
    QED_DUP
  } qed_state_e;

  // x0 stays x0 so hard-wired zero reads keep their meaning in the duplicate.
  function automatic logic [4:0] remap_field(input logic [4:0] r);
    logic [4:0] f;
    f = r;
    if (r != 5'd0) f[REG_DUP_BIT] = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/qed_reg_remap.sv
// Combinational remap of an original RV32I instruction into its duplicate,
// which uses the upper half of the register file.
module qed_reg_remap
  import qed_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [31:0] o_instr
);

  always_comb begin
    o_instr = i_instr;
    case (i_instr[6:0])
      OP_R: begin
        o_instr[11:7]  = remap_field(i_instr[11:7]);
        o_instr[19:15] = remap_field(i_instr[19:15]);
        o_instr[24:20] = remap_field(i_instr[24:20]);
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        o_instr[11:7]  = remap_field(i_instr[11:7]);
        o_instr[19:15] = remap_field(i_instr[19:15]);
      end
      OP_STORE, OP_BRANCH: begin
        o_instr[19:15] = remap_field(i_instr[19:15]);
        o_instr[24:20] = remap_field(i_instr[24:20]);
      end
      // Upper bits in U/J formats are immediate, so only rd is touched.
      OP_LUI, OP_AUIPC, OP_JAL: begin
        o_instr[11:7]  = remap_field(i_instr[11:7]);
      end
      default: o_instr = QED_NOP;
    endcase
  end

endmodule

// File: rtl/qed_dup_issue_ctrl.sv
// QED producer: records originals accepted in ORIG mode, then replays them
// register-remapped in DUP mode and flags each completed batch for checking.
module qed_dup_issue_ctrl
  import qed_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_ena,
  input  logic [31:0]   i_ifu_qed_instruction,
  input  logic          i_ifu_valid,
  input  logic          i_stall,
  input  logic          i_qed_switch,
  output logic          o_exec_dup,
  output logic [31:0]   o_qed_instruction,
  output logic          o_qed_check_valid,
  output logic [AW:0]   o_qed_count
);

  localparam logic [AW:0] LP_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] LP_ONE  = (AW + 1)'(1);

  qed_state_e    r_state;
  qed_state_e    w_next_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_next;
  logic [31:0]   r_buf [DEPTH];
  logic          r_exec_dup;
  logic          r_check_valid;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_check_next;
  logic [31:0]   w_dup_instr;

  assign w_accept = i_ifu_valid & ~i_stall;

  // Dropping ena wins over stall so a disabled QED never leaves a stale batch.
  always_comb begin
    w_next_state = r_state;
    w_count_next = r_count;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_flush      = 1'b0;
    w_check_next = 1'b0;
    if (!i_ena) begin
      w_next_state = QED_IDLE;
      w_flush      = 1'b1;
      w_count_next = '0;
    end else begin
      case (r_state)
        QED_IDLE: begin
          if (!i_stall) w_next_state = QED_ORIG;
        end
        QED_ORIG: begin
          w_push = w_accept;
          if (w_push) w_count_next = r_count + LP_ONE;
          if (!i_stall && (w_count_next == LP_FULL ||
                           (i_qed_switch && w_count_next != '0)))
            w_next_state = QED_DUP;
        end
        QED_DUP: begin
          w_pop = w_accept && (r_count != '0);
          if (w_pop) begin
            w_count_next = r_count - LP_ONE;
            if (r_count == LP_ONE) begin
              w_next_state = QED_ORIG;
              w_check_next = 1'b1;
            end
          end
        end
        default: w_next_state = QED_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= QED_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_exec_dup    <= 1'b0;
      r_check_valid <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_count       <= w_count_next;
      r_exec_dup    <= (w_next_state == QED_DUP);
      r_check_valid <= w_check_next;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Storage carries no reset; validity is tracked entirely by the count.
  always_ff @(posedge i_clk) begin
    if (w_push) r_buf[r_wr_ptr] <= i_ifu_qed_instruction;
  end

  qed_reg_remap u_remap (
    .i_instr (r_buf[r_rd_ptr]),
    .o_instr (w_dup_instr)
  );

  assign o_exec_dup        = r_exec_dup;
  assign o_qed_instruction = (r_state == QED_DUP) ? w_dup_instr : QED_NOP;
  assign o_qed_check_valid = r_check_valid;
  assign o_qed_count       = r_count;

endmodule

// File: tb/tb_qed_dup_issue_ctrl.sv
// Directed bench for qed_dup_issue_ctrl: batch record/replay, full-buffer entry,
// stall freeze, remap corner opcodes, ena drop and push-with-switch.
module tb_qed_dup_issue_ctrl;

  localparam logic [31:0] ADD      = 32'h0020_81B3;
  localparam logic [31:0] ADD_DUP  = 32'h0128_89B3;
  localparam logic [31:0] LUI      = 32'h1234_52B7;
  localparam logic [31:0] LUI_DUP  = 32'h1234_5AB7;
  localparam logic [31:0] ECALL    = 32'h0000_0073;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [31:0] ifuInstr;
  logic        ifuValid;
  logic        stall;
  logic        qedSwitch;
  logic        execDup;
  logic [31:0] qedInstr;
  logic        checkValid;
  logic [3:0]  qedCount;

  int checks = 0;
  int errors = 0;

  logic [31:0] batch    [8];
  logic [31:0] batchDup [8];

  always #5 clk = ~clk;

  qed_dup_issue_ctrl #(.DEPTH(8)) dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_ena                 (ena),
    .i_ifu_qed_instruction (ifuInstr),
    .i_ifu_valid           (ifuValid),
    .i_stall               (stall),
    .i_qed_switch          (qedSwitch),
    .o_exec_dup            (execDup),
    .o_qed_instruction     (qedInstr),
    .o_qed_check_valid     (checkValid),
    .o_qed_count           (qedCount)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      $error("[TB] %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic expDup,
                            input int expCount, input logic expCheck);
    checkOutput({tag, ".exec_dup"}, {31'd0, execDup}, {31'd0, expDup});
    checkOutput({tag, ".count"}, {28'd0, qedCount}, 32'(expCount));
    checkOutput({tag, ".check_valid"}, {31'd0, checkValid}, {31'd0, expCheck});
  endtask

  // Inputs change 1 time unit after a rising edge, outputs are read there too.
  task automatic applyStimulus(input logic e, input logic v, input logic s,
                               input logic sw, input logic [31:0] instr);
    ena       = e;
    ifuValid  = v;
    stall     = s;
    qedSwitch = sw;
    ifuInstr  = instr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    rst = 1'b0;
    checkState("reset", 0, 0, 0);
    checkOutput("reset.instr", qedInstr, NOP);

    $display("[TB] scenario 1: three ADDs then switch");
    applyStimulus(1, 0, 0, 0, 32'h0);
    checkState("s1.orig", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 0, ADD);
      checkState("s1.push", 0, i + 1, 0);
    end
    applyStimulus(1, 0, 0, 1, 32'h0);
    checkState("s1.dup", 1, 3, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("s1.instr", qedInstr, ADD_DUP);
      applyStimulus(1, 1, 0, 0, 32'hDEAD_BEEF);
      if (i < 2) checkState("s1.pop", 1, 2 - i, 0);
      else       checkState("s1.last", 0, 0, 1);
    end
    applyStimulus(1, 0, 0, 0, 32'h0);
    checkState("s1.after", 0, 0, 0);

    $display("[TB] scenario 2: fill to depth");
    for (int i = 0; i < 8; i++) begin
      batch[i]    = (32'(i) << 20) | (32'(i + 1) << 15) | (32'(i + 1) << 7) | 32'h13;
      batchDup[i] = batch[i] | 32'h0000_0800 | 32'h0008_0000;
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, 0, 0, batch[i]);
      if (i < 7) checkState("s2.push", 0, i + 1, 0);
      else       checkState("s2.full", 1, 8, 0);
    end
    for (int i = 0; i < 8; i++) begin
      checkOutput("s2.instr", qedInstr, batchDup[i]);
      applyStimulus(1, 1, 0, 0, ECALL);
      if (i < 7) checkState("s2.pop", 1, 7 - i, 0);
      else       checkState("s2.last", 0, 0, 1);
    end

    $display("[TB] scenario 3: stall in DUP");
    applyStimulus(1, 1, 0, 0, ADD);
    applyStimulus(1, 1, 0, 0, LUI);
    applyStimulus(1, 0, 0, 1, 32'h0);
    checkState("s3.dup", 1, 2, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 1, 1, ECALL);
      checkState("s3.stall", 1, 2, 0);
      checkOutput("s3.stall.instr", qedInstr, ADD_DUP);
    end
    applyStimulus(1, 1, 0, 0, 32'h0);
    checkState("s3.resume", 1, 1, 0);
    checkOutput("s3.resume.instr", qedInstr, LUI_DUP);
    applyStimulus(1, 1, 0, 0, 32'h0);
    checkState("s3.last", 0, 0, 1);

    $display("[TB] scenario 4: LUI and ECALL");
    applyStimulus(1, 0, 0, 0, 32'h0);
    applyStimulus(1, 1, 0, 0, LUI);
    checkState("s4.push", 0, 1, 0);
    applyStimulus(1, 1, 0, 1, ECALL);
    checkState("s4.dup", 1, 2, 0);
    checkOutput("s4.lui", qedInstr, LUI_DUP);
    applyStimulus(1, 1, 0, 0, 32'h0);
    checkState("s4.pop", 1, 1, 0);
    checkOutput("s4.ecall", qedInstr, NOP);
    applyStimulus(1, 1, 0, 0, 32'h0);
    checkState("s4.last", 0, 0, 1);

    $display("[TB] scenario 5: ena drop mid-DUP");
    applyStimulus(1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, LUI);
    applyStimulus(1, 0, 0, 1, 32'h0);
    checkState("s5.dup", 1, 4, 0);
    applyStimulus(0, 1, 0, 0, ADD);
    checkState("s5.drop", 0, 0, 0);
    checkOutput("s5.drop.instr", qedInstr, NOP);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkState("s5.idle", 0, 0, 0);
    applyStimulus(1, 1, 0, 0, ECALL);
    checkState("s5.reenable", 0, 0, 0);
    applyStimulus(1, 1, 0, 0, ADD);
    checkState("s5.push", 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 32'h0);
    checkState("s5.dup2", 1, 1, 0);
    checkOutput("s5.instr", qedInstr, ADD_DUP);
    applyStimulus(1, 1, 0, 0, 32'h0);
    checkState("s5.last", 0, 0, 1);

    $display("[TB] scenario 6: switch with empty buffer");
    applyStimulus(1, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 1, 32'h0);
    checkState("s6.ignored", 0, 0, 0);
    applyStimulus(1, 1, 0, 1, ADD);
    checkState("s6.pushsw", 1, 1, 0);
    checkOutput("s6.instr", qedInstr, ADD_DUP);
    applyStimulus(1, 1, 0, 0, 32'h0);
    checkState("s6.last", 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
